sdblkrx: RTL and testbench

//  Host-side SDIO data-block receiver (card->host). Takes pre-sampled DAT[7:0] lane values from the

---
 rtl/sdblkrx_pkg.sv | 36 +++
 rtl/sdblkrx_if.sv | 12 +
 rtl/sdblkrx_crc.sv | 32 +++
 rtl/sdblkrx.sv | 206 ++++++++++++++++++++
 tb/tb_sdblkrx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdblkrx_pkg.sv
// Shared constants and types for the SDIO data-block receiver.
package sdblkrx_pkg;

  localparam logic [15:0] CrcPoly = 16'h1021;

  localparam logic [1:0] W1 = 2'd0;
  localparam logic [1:0] W4 = 2'd1;
  localparam logic [1:0] W8 = 2'd2;

  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatCrc     = 2'd1;
  localparam logic [1:0] StatEnd     = 2'd2;
  localparam logic [1:0] StatTimeout = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StWaitStart, StStart, StData, StCrc, StEnd, StDone
  } state_e;

  // Width code 3 is illegal and behaves as 8-lane.
  function automatic logic [7:0] lane_mask(logic [1:0] width);
    case (width)
      W1:      return 8'h01;
      W4:      return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] lane_bits(logic [1:0] width);
    case (width)
      W1:      return 4'd1;
      W4:      return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sdblkrx_if.sv
// Sample stream from the PHY and the word/status stream towards the RX FIFO.
interface sdblkrx_if;
  logic [1:0]  rx_strb;
  logic [15:0] rx_data;
  logic        wr;
  logic [31:0] data;
  logic        done;
  logic [1:0]  status;

  modport master (output rx_strb, rx_data, input wr, data, done, status);
  modport slave  (input rx_strb, rx_data, output wr, data, done, status);
endinterface

// File: rtl/sdblkrx_crc.sv
// One lane/edge CRC16. Received CRC bits are stepped in after the payload, so a
// good block leaves the register at zero; zero_o looks at the next value.
module sdblkrx_crc
  import sdblkrx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic step_i,
  input  logic bit_i,
  output logic zero_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (step_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_i) ? CrcPoly : 16'h0000);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign zero_o = (crc_d == 16'h0000);

endmodule

// File: rtl/sdblkrx.sv
// SDIO card->host data-block receiver: start detect, MSB-first word packing, CRC16 and end bit.
// Define SDBLKRX_CRC_EN to compare the per-lane/edge CRC16; otherwise CRC samples are discarded.
module sdblkrx
  import sdblkrx_pkg::*;
#(
  parameter int unsigned LGLEN     = 12,
  parameter int unsigned LGTIMEOUT = 23
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_width,
  input  logic             i_ddr,
  input  logic [LGLEN-1:0] i_length,
  sdblkrx_if.slave         bus
);

  localparam int unsigned BitW = LGLEN + 3;

  state_e               state_q, state_d;
  logic [LGLEN-1:0]     len_q, len_d;
  logic [BitW-1:0]      bits_q, bits_d;
  logic [5:0]           nbits_q, nbits_d;
  logic [31:0]          sreg_q, sreg_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [LGTIMEOUT-1:0] timer_q, timer_d;
  logic                 flush_q, flush_d;
  logic                 wr_q, wr_d;
  logic [31:0]          data_q, data_d;
  logic                 done_q, done_d;
  logic [1:0]           status_q, status_d;

  logic        word_v, fin_end, fin_to, end_ok, smp_v;
  logic [31:0] word;
  logic [7:0]  lanes, mask;
  logic [3:0]  nb;
  logic        crc_clr, crc_ok;
  logic [15:0] crc_step, crc_bit;

  assign mask = lane_mask(i_width);
  assign nb   = lane_bits(i_width);

  // Both samples of a cycle are walked in order, so one cycle may cross several states.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bits_d   = bits_q;
    nbits_d  = nbits_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    flush_d  = 1'b0;
    word_v   = 1'b0;
    word     = sreg_q;
    fin_end  = 1'b0;
    fin_to   = 1'b0;
    end_ok   = 1'b0;
    crc_clr  = 1'b0;
    crc_step = '0;
    crc_bit  = '0;
    smp_v    = 1'b0;
    lanes    = '0;
    if (state_q == StIdle) begin
      if (i_en) begin
        state_d = StWaitStart;
        len_d   = i_length;
        bits_d  = '0;
        nbits_d = '0;
        sreg_d  = '0;
        cnt_d   = '0;
        timer_d = '0;
        crc_clr = 1'b1;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        smp_v = (s == 0) ? bus.rx_strb[1] : (bus.rx_strb[0] && i_ddr);
        lanes = (s == 0) ? bus.rx_data[15:8] : bus.rx_data[7:0];
        if (smp_v) begin
          case (state_d)
            StWaitStart: if (!lanes[0]) state_d = i_ddr ? StStart : StData;
            StStart:     state_d = StData;
            StData: begin
              crc_step[s*8 +: 8] = mask;
              crc_bit[s*8 +: 8]  = lanes;
              sreg_d  = (sreg_d << nb) | 32'(lanes & mask);
              nbits_d = nbits_d + 6'(nb);
              bits_d  = bits_d + BitW'(nb);
              if (nbits_d == 6'd32) begin
                word_v  = 1'b1;
                word    = sreg_d;
                nbits_d = '0;
              end
              if (bits_d == {len_q, 3'b000}) begin
                state_d = StCrc;
                cnt_d   = '0;
                flush_d = (nbits_d != 6'd0);
              end
            end
            StCrc: begin
              crc_step[s*8 +: 8] = mask;
              crc_bit[s*8 +: 8]  = lanes;
              if (cnt_d == (i_ddr ? 5'd31 : 5'd15)) state_d = StEnd;
              cnt_d = cnt_d + 5'd1;
            end
            StEnd: begin
              end_ok  = ((lanes & mask) == mask);
              fin_end = 1'b1;
              state_d = StDone;
            end
            default: ;
          endcase
        end
      end
      if (state_q == StWaitStart) begin
        timer_d = timer_q + LGTIMEOUT'(1);
        if (state_d == StWaitStart && (&timer_q)) begin
          fin_to  = 1'b1;
          state_d = StDone;
        end
      end
      // Disarming abandons the block silently, including any partial word.
      if (!i_en) begin
        state_d = StIdle;
        flush_d = 1'b0;
        word_v  = 1'b0;
        fin_end = 1'b0;
        fin_to  = 1'b0;
      end
    end
  end

  always_comb begin
    wr_d     = 1'b0;
    data_d   = data_q;
    done_d   = fin_end | fin_to;
    status_d = status_q;
    if (word_v) begin
      wr_d   = 1'b1;
      data_d = word;
    end else if (flush_q && i_en) begin
      wr_d   = 1'b1;
      data_d = sreg_q << (6'd32 - nbits_q);
    end
    if (fin_to) begin
      status_d = StatTimeout;
    end else if (fin_end) begin
      status_d = !crc_ok ? StatCrc : (!end_ok ? StatEnd : StatOk);
    end
  end

`ifdef SDBLKRX_CRC_EN
  logic [15:0] crc_zero;
  // Index = edge*8 + lane; edge 0 is the first (rising) sample.
  for (genvar g = 0; g < 16; g++) begin : g_crc
    sdblkrx_crc u_crc (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .clr_i  (crc_clr),
      .step_i (crc_step[g]),
      .bit_i  (crc_bit[g]),
      .zero_o (crc_zero[g])
    );
  end
  assign crc_ok = &crc_zero;
`else
  logic unused_crc;
  assign unused_crc = ^{crc_clr, crc_step, crc_bit};
  assign crc_ok     = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      bits_q   <= '0;
      nbits_q  <= '0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      flush_q  <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      status_q <= StatOk;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      bits_q   <= bits_d;
      nbits_q  <= nbits_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      flush_q  <= flush_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign bus.wr     = wr_q;
  assign bus.data   = data_q;
  assign bus.done   = done_q;
  assign bus.status = status_q;

endmodule

// File: tb/tb_sdblkrx.sv
// Bench for sdblkrx: builds whole lane-sample streams (start, payload, CRC16, end bit) from a
// byte payload and checks delivered words and block status against values derived from it.
module tb_sdblkrx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  width;
  logic        ddr;
  logic [11:0] length;

  sdblkrx_if bus ();

  sdblkrx #(.LGLEN(12), .LGTIMEOUT(4)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_en     (en),
    .i_width  (width),
    .i_ddr    (ddr),
    .i_length (length),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] got_q[$];
  int          done_n;
  int          done_cyc;
  logic [1:0]  stat_got;
  logic [7:0]  pay[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr) got_q.push_back(bus.data);
    if (bus.done) begin
      done_n++;
      stat_got = bus.status;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic idle_bus();
    bus.rx_strb = 2'b00;
    bus.rx_data = 16'($urandom());
  endtask

  task automatic clear_mon();
    @(posedge clk);
    got_q.delete();
    done_n = 0;
  endtask

  // drop >= 0: disarm after that many payload samples (SDR only); no status expected then.
  task automatic run_block(input logic [1:0] w, input bit dd, input int len, input bit odd,
                           input bit flip, input bit badend, input int drop, input string tag);
    logic [7:0]  slots[$];
    logic [15:0] crc[2][8];
    int          pos[2];
    logic [7:0]  m, v;
    logic [31:0] ew;
    int          nbw, npre, d0, e, fk, i, nexp;
    logic [1:0]  sexp;
    bit          dropped;
    m   = (w == 2'd0) ? 8'h01 : (w == 2'd1) ? 8'h0F : 8'hFF;
    nbw = (w == 2'd0) ? 1 : (w == 2'd1) ? 4 : 8;
    for (int a = 0; a < 2; a++) for (int l = 0; l < 8; l++) crc[a][l] = '0;
    pos[0] = 0;
    pos[1] = 0;
    npre = dd ? ((odd ? 1 : 0) + 2 * $urandom_range(0, 1)) : $urandom_range(0, 3);
    repeat (npre) slots.push_back(8'($urandom()) | 8'h01);
    slots.push_back(8'($urandom()) & 8'hFE);
    if (dd) slots.push_back(8'($urandom()));
    d0 = slots.size();
    foreach (pay[j]) begin
      for (int k = 8 / nbw - 1; k >= 0; k--) begin
        v = ((pay[j] >> (k * nbw)) & m) | (8'($urandom()) & ~m);
        e = dd ? slots.size() % 2 : 0;
        for (int l = 0; l < 8; l++) if (m[l]) crc[e][l] = crc16_step(crc[e][l], v[l]);
        slots.push_back(v);
      end
    end
    fk = flip ? $urandom_range(0, dd ? 31 : 15) : -1;
    for (int k = 0; k < (dd ? 32 : 16); k++) begin
      e = dd ? slots.size() % 2 : 0;
      v = 8'($urandom()) & ~m;
      for (int l = 0; l < 8; l++) if (m[l]) v[l] = crc[e][l][15 - pos[e]];
      pos[e]++;
      if (k == fk) v[0] = ~v[0];
      slots.push_back(v);
    end
    v = (8'($urandom()) & ~m) | m;
    if (badend) v[(w == 2'd0) ? 0 : 2] = 1'b0;
    slots.push_back(v);
    repeat (3) slots.push_back(8'hFF);

    width  = w;
    ddr    = dd;
    length = 12'(len);
    clear_mon();
    @(negedge clk);
    en = 1'b1;
    i = 0;
    dropped = 1'b0;
    while (i < slots.size()) begin
      @(negedge clk);
      if (drop >= 0 && i >= d0 + drop) begin
        en = 1'b0;
        idle_bus();
        dropped = 1'b1;
        break;
      end
      if (i > d0 && $urandom_range(0, 7) == 0) begin
        idle_bus();
      end else if (dd) begin
        bus.rx_strb = 2'b11;
        bus.rx_data = {slots[i], (i + 1 < slots.size()) ? slots[i + 1] : 8'hFF};
        i += 2;
      end else begin
        bus.rx_strb = {1'b1, 1'($urandom())};
        bus.rx_data = {slots[i], 8'($urandom())};
        i++;
      end
    end
    @(negedge clk);
    idle_bus();

    if (dropped) begin
      repeat (20) @(posedge clk);
      nexp = (drop * nbw) / 32;
      chk({tag, "_done_cnt"}, 32'(done_n), 32'd0);
    end else begin
      for (int t = 0; t < 40 && done_n == 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      nexp = (len + 3) / 4;
      sexp = 2'd0;
      if (flip) begin
`ifdef SDBLKRX_CRC_EN
        sexp = 2'd1;
`endif
      end else if (badend) begin
        sexp = 2'd2;
      end
      chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
      chk({tag, "_status"}, 32'(stat_got), 32'(sexp));
    end
    chk({tag, "_word_cnt"}, 32'(got_q.size()), 32'(nexp));
    for (int n = 0; n < nexp && n < got_q.size(); n++) begin
      ew = '0;
      for (int b = 0; b < 4; b++) if (4 * n + b < len) ew[31 - 8 * b -: 8] = pay[4 * n + b];
      chk($sformatf("%s_word%0d", tag, n), got_q[n], ew);
    end
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_pay(input int len);
    pay.delete();
    repeat (len) pay.push_back(8'($urandom()));
  endtask

  initial begin
    int arm_cyc;
    rst    = 1'b1;
    en     = 1'b0;
    width  = 2'd0;
    ddr    = 1'b0;
    length = 12'd4;
    done_n = 0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", 32'(bus.wr), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_data", bus.data, 32'd0);
    rst = 1'b0;

    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_block(2'd0, 1'b0, 4, 1'b0, 1'b0, 1'b0, -1, "w1_deadbeef");

    pay.delete();
    for (int k = 0; k < 512; k++) pay.push_back(8'(k));
    run_block(2'd1, 1'b0, 512, 1'b0, 1'b0, 1'b0, -1, "w4_inc512");

    pay = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    run_block(2'd2, 1'b1, 8, 1'b1, 1'b0, 1'b0, -1, "w8_ddr_odd");

    rand_pay(5);
    run_block(2'd0, 1'b0, 5, 1'b0, 1'b1, 1'b0, -1, "w1_crcflip");

    rand_pay(8);
    run_block(2'd1, 1'b0, 8, 1'b0, 1'b0, 1'b1, -1, "w4_badend");

    // Start-bit timeout: index 0 is the first edge after the arming edge.
    width  = 2'd1;
    ddr    = 1'b0;
    length = 12'd4;
    clear_mon();
    @(negedge clk);
    en = 1'b1;
    arm_cyc = cyc;
    bus.rx_strb = 2'b10;
    bus.rx_data = 16'hFFFF;
    for (int t = 0; t < 40 && done_n == 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("timeout_done_cnt", 32'(done_n), 32'd1);
    chk("timeout_cycle", 32'(done_cyc - arm_cyc - 2), 32'd15);
    chk("timeout_status", 32'(stat_got), 32'd3);
    chk("timeout_words", 32'(got_q.size()), 32'd0);
    @(negedge clk);
    en = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);

    rand_pay(6);
    run_block(2'd2, 1'b0, 6, 1'b0, 1'b0, 1'b0, 5, "drop_mid");
    rand_pay(6);
    run_block(2'd2, 1'b0, 6, 1'b0, 1'b0, 1'b0, -1, "rearm");

    for (int r = 0; r < 10; r++) begin
      int rl;
      rl = $urandom_range(1, 24);
      rand_pay(rl);
      run_block(2'($urandom_range(0, 3)), 1'($urandom()), rl, 1'($urandom()), 1'b0, 1'b0, -1,
                $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
